// File: rtl/rc_servo_pwm_decoder_xy.sv
// Two-channel RC servo PWM receiver: measures pulse high time per channel and
// converts it to an 8-bit position with an update strobe and a link-lock flag.

// state  | meaning
// IDLE   | waiting for a rising edge on the synchronized pin
// HIGH   | pulse in progress, prescaler and tick count running
// OVER   | pulse exceeded MAX_VALID, waiting for fall and discarding it
module rc_pwm_chan #(
  parameter int DIV         = 39,
  parameter int MIN_TICKS   = 256,
  parameter int MIN_VALID   = 192,
  parameter int MAX_VALID   = 576,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ena,
  input  logic       i_pwm,
  output logic [7:0] o_pos,
  output logic       o_upd,
  output logic       o_lock
);

  localparam int                 PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]      PSC_LAST = PW'(DIV - 1);
  localparam logic [9:0]         MINV     = 10'(MIN_VALID);
  localparam logic [9:0]         MAXV     = 10'(MAX_VALID);
  localparam logic signed [10:0] MIN_S    = 11'(MIN_TICKS);
  localparam logic [17:0]        TO_LAST  = 18'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_OVER} state_t;

  state_t             r_state;
  logic               r_s1, r_s2, r_prev;
  logic [PW-1:0]      r_psc;
  logic [9:0]         r_tcnt;
  logic [17:0]        r_to_cnt;
  logic [7:0]         r_pos;
  logic               r_upd, r_lock;

  logic               w_rise, w_fall, w_psc_wrap, w_accept;
  logic [9:0]         w_tcnt_nxt;
  logic signed [10:0] w_diff;
  logic [7:0]         w_pos_nxt;

  // The fall cycle itself still advances the prescaler, so the evaluated
  // count is floor(H/DIV) with H the number of high samples on the pin.
  always_comb begin
    w_rise     = r_s2 & ~r_prev;
    w_fall     = ~r_s2 & r_prev;
    w_psc_wrap = (r_psc == PSC_LAST);
    w_tcnt_nxt = r_tcnt;
    if (w_psc_wrap && (r_tcnt != 10'h3FF)) w_tcnt_nxt = r_tcnt + 10'd1;
    w_diff   = $signed({1'b0, w_tcnt_nxt}) - MIN_S;
    w_accept = (w_tcnt_nxt >= MINV) && (w_tcnt_nxt <= MAXV);
    if (w_diff[10])              w_pos_nxt = 8'd0;
    else if (w_diff > 11'sd255)  w_pos_nxt = 8'hFF;
    else                         w_pos_nxt = w_diff[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_prev   <= 1'b1;
      r_state  <= S_IDLE;
      r_psc    <= '0;
      r_tcnt   <= '0;
      r_to_cnt <= '0;
      r_pos    <= 8'h80;
      r_upd    <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_s1   <= i_pwm;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_upd  <= 1'b0;
      if (!i_ena) begin
        r_state  <= S_IDLE;
        r_psc    <= '0;
        r_tcnt   <= '0;
        r_to_cnt <= '0;
      end else begin
        if (r_to_cnt == TO_LAST) r_lock   <= 1'b0;
        else                     r_to_cnt <= r_to_cnt + 18'd1;
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state <= S_HIGH;
              r_psc   <= '0;
              r_tcnt  <= '0;
            end
          end
          S_HIGH: begin
            r_psc  <= w_psc_wrap ? '0 : r_psc + PW'(1);
            r_tcnt <= w_tcnt_nxt;
            if (w_fall) begin
              r_state <= S_IDLE;
              if (w_accept) begin
                r_pos    <= w_pos_nxt;
                r_upd    <= 1'b1;
                r_lock   <= 1'b1;
                r_to_cnt <= '0;
              end
            end else if (w_tcnt_nxt > MAXV) begin
              r_state <= S_OVER;
            end
          end
          S_OVER: begin
            if (w_fall) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_pos  = r_pos;
  assign o_upd  = r_upd;
  assign o_lock = r_lock;

endmodule

module rc_servo_pwm_decoder_xy #(
  parameter int DIV         = 39,
  parameter int MIN_TICKS   = 256,
  parameter int MIN_VALID   = 192,
  parameter int MAX_VALID   = 576,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pwm_x_i,
  input  logic       pwm_y_i,
  output logic [7:0] pos_x_o,
  output logic [7:0] pos_y_o,
  output logic       upd_x_o,
  output logic       upd_y_o,
  output logic       lock_x_o,
  output logic       lock_y_o
);

  rc_pwm_chan #(
    .DIV(DIV), .MIN_TICKS(MIN_TICKS), .MIN_VALID(MIN_VALID),
    .MAX_VALID(MAX_VALID), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_chan_x (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_pwm(pwm_x_i),
    .o_pos(pos_x_o), .o_upd(upd_x_o), .o_lock(lock_x_o)
  );

  rc_pwm_chan #(
    .DIV(DIV), .MIN_TICKS(MIN_TICKS), .MIN_VALID(MIN_VALID),
    .MAX_VALID(MAX_VALID), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_chan_y (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_pwm(pwm_y_i),
    .o_pos(pos_y_o), .o_upd(upd_y_o), .o_lock(lock_y_o)
  );

endmodule

// File: tb/tb_rc_servo_pwm_decoder_xy.sv
// Scoreboard bench for rc_servo_pwm_decoder_xy; runs with a short prescaler and
// timeout so pulse widths are H = 4*ticks + 2 cycles.
module tb_rc_servo_pwm_decoder_xy;

  localparam int DIV = 4;
  localparam int TO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       pwm_x_i = 1'b1;
  logic       pwm_y_i = 1'b0;
  logic [7:0] pos_x_o, pos_y_o;
  logic       upd_x_o, upd_y_o, lock_x_o, lock_y_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct { int cyc; int pos; } exp_t;
  exp_t q_x[$];
  exp_t q_y[$];

  rc_servo_pwm_decoder_xy #(
    .DIV(DIV), .MIN_TICKS(256), .MIN_VALID(192), .MAX_VALID(576),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .pwm_x_i(pwm_x_i), .pwm_y_i(pwm_y_i),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
    .upd_x_o(upd_x_o), .upd_y_o(upd_y_o),
    .lock_x_o(lock_x_o), .lock_y_o(lock_y_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of its channel queue.
  always @(negedge clk) begin
    exp_t e;
    if (upd_x_o) begin
      if (q_x.size() == 0) check("upd_x unexpected", 1, 0);
      else begin
        e = q_x.pop_front();
        check("upd_x cycle", cyc, e.cyc);
        check("pos_x", int'(pos_x_o), e.pos);
        check("lock_x at upd", int'(lock_x_o), 1);
      end
    end
    if (upd_y_o) begin
      if (q_y.size() == 0) check("upd_y unexpected", 1, 0);
      else begin
        e = q_y.pop_front();
        check("upd_y cycle", cyc, e.cyc);
        check("pos_y", int'(pos_y_o), e.pos);
        check("lock_y at upd", int'(lock_y_o), 1);
      end
    end
  end

  task automatic pulse_x(input int h, input bit acc, input int pos);
    exp_t e;
    @(negedge clk) pwm_x_i = 1'b1;
    repeat (h) @(negedge clk);
    pwm_x_i = 1'b0;
    if (acc) begin
      e.cyc = cyc + 3;
      e.pos = pos;
      q_x.push_back(e);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    // reset with X pin high
    repeat (4) @(negedge clk);
    check("rst pos_x", int'(pos_x_o), 8'h80);
    check("rst pos_y", int'(pos_y_o), 8'h80);
    check("rst upd_x", int'(upd_x_o), 0);
    check("rst upd_y", int'(upd_y_o), 0);
    check("rst lock_x", int'(lock_x_o), 0);
    check("rst lock_y", int'(lock_y_o), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pwm_x_i = 1'b0;
    repeat (20) @(negedge clk);
    check("no edge after rst pos_x", int'(pos_x_o), 8'h80);
    check("no edge after rst lock_x", int'(lock_x_o), 0);

    // nominal and rejected pulses
    pulse_x(1538, 1'b1, 128);
    pulse_x(514, 1'b0, 0);
    check("short hold pos_x", int'(pos_x_o), 128);
    check("short hold lock_x", int'(lock_x_o), 1);
    pulse_x(1026, 1'b1, 0);
    pulse_x(2402, 1'b0, 0);
    check("over hold pos_x", int'(pos_x_o), 0);
    check("over hold lock_x", int'(lock_x_o), 1);
    pulse_x(2050, 1'b1, 255);
    pulse_x(770, 1'b1, 0);
    pulse_x(766, 1'b0, 0);
    check("191 ticks hold pos_x", int'(pos_x_o), 0);
    pulse_x(2306, 1'b1, 255);
    pulse_x(2310, 1'b0, 0);
    check("577 ticks hold pos_x", int'(pos_x_o), 255);

    // simultaneous falls: X 307 ticks, Y 461 ticks
    @(negedge clk) pwm_y_i = 1'b1;
    repeat (1846 - 1230) @(negedge clk);
    pwm_x_i = 1'b1;
    repeat (1230) @(negedge clk);
    pwm_x_i = 1'b0;
    pwm_y_i = 1'b0;
    e.cyc = cyc + 3; e.pos = 51;  q_x.push_back(e);
    e.cyc = cyc + 3; e.pos = 205; q_y.push_back(e);
    repeat (20) @(negedge clk);

    // enable dropped mid-pulse
    @(negedge clk) pwm_x_i = 1'b1;
    repeat (500) @(negedge clk);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    repeat (1028) @(negedge clk);
    pwm_x_i = 1'b0;
    repeat (20) @(negedge clk);
    check("ena hold pos_x", int'(pos_x_o), 51);
    check("ena hold lock_x", int'(lock_x_o), 1);

    // lock timeout
    pulse_x(1538, 1'b1, 128);
    repeat (TO - 100) @(negedge clk);
    check("lock_x before timeout", int'(lock_x_o), 1);
    repeat (150) @(negedge clk);
    check("lock_x after timeout", int'(lock_x_o), 0);
    check("lock_y after timeout", int'(lock_y_o), 0);
    check("pos_x after timeout", int'(pos_x_o), 128);
    check("pos_y after timeout", int'(pos_y_o), 205);

    // reset in the middle of a pulse
    @(negedge clk) pwm_x_i = 1'b1;
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (900) @(negedge clk);
    pwm_x_i = 1'b0;
    repeat (20) @(negedge clk);
    check("mid rst pos_x", int'(pos_x_o), 8'h80);
    check("mid rst lock_x", int'(lock_x_o), 0);
    check("mid rst pos_y", int'(pos_y_o), 8'h80);

    check("x queue drained", q_x.size(), 0);
    check("y queue drained", q_y.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
